// File: rtl/div_pkg.sv
// Shared definitions for the signed sequential divider: FSM states, default
// width and the quotient value reported for a zero divisor.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    // Every bit of the divide-by-zero quotient takes this value (all ones).
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{DBZ_QUOTIENT_BIT}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/prefix_subtractor.sv
// Brent-Kung prefix adder computing a + ~b + 1; the carry-in of one is folded
// into the bit-0 generate term, and borrow is the inverted carry-out.
module prefix_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int LEVELS = $clog2(N);

    // Group carries c[i] = carry out of bits 0..i (up-sweep then down-sweep).
    function automatic logic [N-1:0] prefix_carries(input logic [N-1:0] g_in,
                                                    input logic [N-1:0] p_in);
        logic [N-1:0] g;
        logic [N-1:0] p;
        int           j;
        g = g_in;
        p = p_in;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                j = (i >= (2 ** l)) ? (i - (2 ** l)) : 0;
                if (((i + 1) % (2 ** (l + 1))) == 0) begin
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        for (int l = LEVELS - 2; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                j = (i >= (2 ** l)) ? (i - (2 ** l)) : 0;
                if ((i >= (2 ** (l + 1))) && (((i + 1) % (2 ** (l + 1))) == (2 ** l))) begin
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        return g;
    endfunction

    logic [N-1:0] b_inv_s;
    logic [N-1:0] gen_s;
    logic [N-1:0] prop_s;
    logic [N-1:0] carry_s;

    assign b_inv_s = ~b;
    assign prop_s  = a ^ b_inv_s;
    assign gen_s   = {a[N-1:1] & b_inv_s[N-1:1], (a[0] & b_inv_s[0]) | prop_s[0]};
    assign carry_s = prefix_carries(gen_s, prop_s);
    assign diff    = prop_s ^ {carry_s[N-2:0], 1'b1};
    assign borrow  = ~carry_s[N-1];

endmodule

// File: rtl/signed_seq_divider.sv
// Signed restoring divider: one quotient bit per cycle on operand magnitudes,
// followed by a sign fix-up and a valid/ready result handshake.
module signed_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ZERO_EXT = {(WIDTH+1){1'b0}};

    div_state_e       state_r;
    div_state_e       state_nxt_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   divisor_mag_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dividend_r;
    logic             dvd_neg_r;
    logic             q_neg_r;
    logic             dbz_r;
    logic             ovf_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             out_valid_r;
    logic             dbz_out_r;
    logic             ovf_out_r;

    logic [WIDTH:0]   dividend_ext_s;
    logic [WIDTH:0]   divisor_ext_s;
    logic [WIDTH:0]   dividend_mag_s;
    logic [WIDTH:0]   divisor_mag_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_diff_s;
    logic             trial_borrow_s;
    logic [WIDTH:0]   neg_q_s;
    logic [WIDTH:0]   neg_r_s;
    logic             neg_q_borrow_unused_s;
    logic             neg_r_borrow_unused_s;
    logic             unused_s;

    // Magnitudes are one bit wider so |-2^(WIDTH-1)| does not wrap.
    assign dividend_ext_s = {dividend[WIDTH-1], dividend};
    assign divisor_ext_s  = {divisor[WIDTH-1], divisor};
    assign dividend_mag_s = dividend[WIDTH-1] ? (ZERO_EXT - dividend_ext_s) : dividend_ext_s;
    assign divisor_mag_s  = divisor[WIDTH-1]  ? (ZERO_EXT - divisor_ext_s)  : divisor_ext_s;

    assign shifted_s = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};

    prefix_subtractor #(.N(WIDTH + 1)) u_trial (
        .a      (shifted_s),
        .b      (divisor_mag_r),
        .diff   (trial_diff_s),
        .borrow (trial_borrow_s)
    );

    prefix_subtractor #(.N(WIDTH + 1)) u_neg_q (
        .a      (ZERO_EXT),
        .b      ({1'b0, dvd_r}),
        .diff   (neg_q_s),
        .borrow (neg_q_borrow_unused_s)
    );

    prefix_subtractor #(.N(WIDTH + 1)) u_neg_r (
        .a      (ZERO_EXT),
        .b      (rem_r),
        .diff   (neg_r_s),
        .borrow (neg_r_borrow_unused_s)
    );

    assign unused_s = ^{neg_q_borrow_unused_s, neg_r_borrow_unused_s, neg_q_s[WIDTH],
                        neg_r_s[WIDTH], dividend_mag_s[WIDTH]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == {CW{1'b0}}) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX: begin
                state_nxt_s = DONE;
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture, restoring iteration, sign fix-up and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r       <= {CW{1'b0}};
            rem_r         <= ZERO_EXT;
            divisor_mag_r <= ZERO_EXT;
            dvd_r         <= {WIDTH{1'b0}};
            dividend_r    <= {WIDTH{1'b0}};
            dvd_neg_r     <= 1'b0;
            q_neg_r       <= 1'b0;
            dbz_r         <= 1'b0;
            ovf_r         <= 1'b0;
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            dbz_out_r     <= 1'b0;
            ovf_out_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        count_r       <= CW'(WIDTH - 1);
                        rem_r         <= ZERO_EXT;
                        divisor_mag_r <= divisor_mag_s;
                        dvd_r         <= dividend_mag_s[WIDTH-1:0];
                        dividend_r    <= dividend;
                        dvd_neg_r     <= dividend[WIDTH-1];
                        q_neg_r       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dbz_r         <= (divisor == {WIDTH{1'b0}});
                        ovf_r         <= (dividend == MIN_NEG) && (divisor == {WIDTH{1'b1}});
                        dbz_out_r     <= 1'b0;
                        ovf_out_r     <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= trial_borrow_s ? shifted_s : trial_diff_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], ~trial_borrow_s};
                    if (count_r != {CW{1'b0}}) begin
                        count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    if (dbz_r) begin
                        quotient_r  <= {WIDTH{DBZ_QUOTIENT_BIT}};
                        remainder_r <= dividend_r;
                        dbz_out_r   <= 1'b1;
                    end else if (ovf_r) begin
                        quotient_r  <= MIN_NEG;
                        remainder_r <= {WIDTH{1'b0}};
                        ovf_out_r   <= 1'b1;
                    end else begin
                        quotient_r  <= q_neg_r   ? neg_q_s[WIDTH-1:0] : dvd_r;
                        remainder_r <= dvd_neg_r ? neg_r_s[WIDTH-1:0] : rem_r[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = (state_r == IDLE) && !rst;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_out_r;
    assign overflow    = ovf_out_r;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (WIDTH = 8): directed vector table,
// stall/reset sequences and randomized operands against an integer model.
module tb_signed_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    signed_seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain signed integer division with the two special cases.
    task automatic model(input logic [7:0] a, input logic [7:0] b, output logic [7:0] q,
                         output logic [7:0] r, output logic dz, output logic ov);
        int as;
        int bs;
        as = int'($signed(a));
        bs = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (bs == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (as == -128 && bs == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(as / bs);
            r = 8'(as % bs);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                         output logic [7:0] q, output logic [7:0] r, output logic dz,
                         output logic ov, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        q   = 8'h00;
        r   = 8'h00;
        dz  = 1'b0;
        ov  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!out_valid) begin
            check("valid_timeout", 32'd0, 32'd1);
            return;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        ok = 1'b1;
    endtask

    vec_t vecs[14];

    initial begin
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        logic [7:0] eq;
        logic [7:0] er;
        logic       edz;
        logic       eov;
        int         lat;
        bit         ok;
        bit         seen;
        logic [7:0] a;
        logic [7:0] b;
        int         qs;
        int         rs;
        int         as;
        int         bs;
        bit         prop;

        vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0};
        vecs[3]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{8'd5,   8'h00,  8'hFF, 8'h05, 1'b1, 1'b0};
        vecs[5]  = '{8'h7F,  8'd2,   8'h3F, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{8'hF9,  8'd2,   8'hFD, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'd7,   8'hF9,  8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h80,  8'd1,   8'h80, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h80,  8'h00,  8'hFF, 8'h80, 1'b1, 1'b0};
        vecs[11] = '{8'hFF,  8'h80,  8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'h00;
        divisor   = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {23'd0, in_ready, out_valid, quotient, remainder, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, q, r, dz, ov, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_result", i), {14'd0, q, r, dz, ov},
                      {14'd0, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf});
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
            end
        end

        // Output stall: results frozen, input pulses ignored, no accept on the handshake edge.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("stall_latency", 32'(lat), 32'd10);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold%0d", i),
                  {12'd0, quotient, remainder, div_by_zero, overflow, out_valid, in_ready},
                  {12'd0, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0});
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stall_no_accept", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});

        // Reset in the middle of CALC discards the operation.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_outputs", {14'd0, quotient, remainder, div_by_zero, overflow}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midreset_no_valid", {31'd0, seen}, 32'd0);
        do_op(8'd127, 8'd2, 0, q, r, dz, ov, lat, ok);
        if (ok) begin
            check("after_reset_127_2", {14'd0, q, r, dz, ov}, {14'd0, 8'd63, 8'd1, 1'b0, 1'b0});
            check("after_reset_latency", 32'(lat), 32'd10);
        end

        // Randomized operands, biased toward extreme dividends, nonzero divisors.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 8'h80;
                1:       a = 8'h7F;
                2:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            do begin
                case ($urandom_range(0, 7))
                    0:       b = 8'hFF;
                    1:       b = 8'h80;
                    2:       b = 8'h01;
                    default: b = 8'($urandom);
                endcase
            end while (b == 8'h00);
            do_op(a, b, $urandom_range(0, 2), q, r, dz, ov, lat, ok);
            if (!ok) break;
            model(a, b, eq, er, edz, eov);
            check("rand_result", {14'd0, q, r, dz, ov}, {14'd0, eq, er, edz, eov});
            if (!eov) begin
                as = int'($signed(a));
                bs = int'($signed(b));
                qs = int'($signed(q));
                rs = int'($signed(r));
                prop = (qs * bs + rs == as) && ((rs < 0 ? -rs : rs) < (bs < 0 ? -bs : bs)) &&
                       (rs == 0 || ((rs < 0) == (as < 0)));
                check("rand_identity", {31'd0, prop}, 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
